// File: rtl/bist_ctrl_param.sv
// BIST controller: LFSR pattern source, MISR response compactor, golden-signature compare.
// Define BIST_SIG_DBG_EN to expose the MISR (sig_out) and pattern counter (pat_cnt).
module bist_ctrl_param #(
    parameter int              PI_W         = 35,
    parameter int              PO_W         = 49,
    parameter int              NUM_PATTERNS = 2000,
    parameter int              WARMUP       = 0,
    parameter logic [PI_W-1:0] LFSR_POLY    = PI_W'('h5),
    parameter logic [PI_W-1:0] LFSR_SEED    = PI_W'('h1),
    parameter logic [PO_W-1:0] MISR_POLY    = PO_W'('h21),
    parameter logic [PO_W-1:0] GOLDEN_SIG   = PO_W'('h0),
    localparam int             CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
`ifdef BIST_SIG_DBG_EN
    output logic [PO_W-1:0] sig_out,
    output logic [CW-1:0]   pat_cnt,
`endif
    output logic            bist_busy,
    output logic            bistdone,
    output logic            bistpass
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [PI_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;
    localparam logic [CW-1:0]   LAST     = CW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_t;

    state_t          state;
    logic [PI_W-1:0] lfsr;
    logic [PI_W-1:0] lfsr_step;
    logic [PO_W-1:0] misr;
    logic [PO_W-1:0] misr_step;
    logic [CW-1:0]   cnt;
    logic            misr_en;

    always_comb begin
        lfsr_step = {lfsr[PI_W-2:0], ^(lfsr & LFSR_POLY)};
        if (lfsr_step == '0) lfsr_step = SEED_EFF;
    end

    assign misr_step = {misr[PO_W-2:0], ^(misr & MISR_POLY)} ^ cut_po;

    // Warm-up gate resolved at elaboration so degenerate cases need no compare.
    generate
        if (WARMUP == 0) begin : g_nowarm
            assign misr_en = 1'b1;
        end else if (WARMUP >= NUM_PATTERNS) begin : g_allwarm
            assign misr_en = 1'b0;
        end else begin : g_warm
            assign misr_en = (cnt >= CW'(WARMUP));
        end
    endgenerate

    assign cut_pi = (state == IDLE) ? pi : lfsr;

`ifdef BIST_SIG_DBG_EN
    assign sig_out = misr;
    assign pat_cnt = cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            misr      <= '0;
            cnt       <= '0;
            bist_busy <= 1'b0;
            bistdone  <= 1'b0;
            bistpass  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bistmode) begin
                    // Seed on entry so INIT already presents the first pattern.
                    state     <= INIT;
                    lfsr      <= SEED_EFF;
                    misr      <= '0;
                    cnt       <= '0;
                    bist_busy <= 1'b1;
                    bistdone  <= 1'b0;
                    bistpass  <= 1'b0;
                end
                INIT: if (!bistmode) begin
                    state     <= IDLE;
                    bist_busy <= 1'b0;
                end else begin
                    state    <= RUN;
                    lfsr     <= SEED_EFF;
                    misr     <= '0;
                    cnt      <= '0;
                    bistdone <= 1'b0;
                    bistpass <= 1'b0;
                end
                RUN: if (!bistmode) begin
                    state     <= IDLE;
                    bist_busy <= 1'b0;
                end else begin
                    lfsr <= lfsr_step;
                    cnt  <= cnt + CW'(1);
                    if (misr_en) misr <= misr_step;
                    if (cnt == LAST) begin
                        state     <= CMP;
                        bist_busy <= 1'b0;
                    end
                end
                CMP: begin
                    bistpass <= (misr == GOLDEN_SIG);
                    bistdone <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (!bistmode) begin
                    state    <= IDLE;
                    bistdone <= 1'b0;
                    bistpass <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bist_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Directed bench for bist_ctrl_param: several small configurations share one clock.
module tb_bist_ctrl_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       bistmode;
    logic [3:0] pi;
    logic [3:0] cut_po_d;
    logic [3:0] zero4 = 4'h0;
    logic [3:0] one4  = 4'h1;

    logic [3:0] pi_a, pi_b, pi_c, pi_d, pi_e;
    logic       busy_a, busy_b, busy_c, busy_d, busy_e;
    logic       done_a, done_b, done_c, done_d, done_e;
    logic       pass_a, pass_b, pass_c, pass_d, pass_e;
`ifdef BIST_SIG_DBG_EN
    logic [3:0] sig_a, sig_b, sig_c, sig_d, sig_e;
    logic [4:0] cnt_a;
    logic [5:0] cnt_b;
    logic [1:0] cnt_c, cnt_d, cnt_e;
`endif

    int nchk = 0;
    int nerr = 0;

    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always #5 clk = ~clk;

    bist_ctrl_param #(.PI_W(4), .PO_W(4), .NUM_PATTERNS(16), .WARMUP(0),
        .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b1100), .GOLDEN_SIG(4'h0))
    u_a (.clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_po(zero4), .cut_pi(pi_a),
`ifdef BIST_SIG_DBG_EN
        .sig_out(sig_a), .pat_cnt(cnt_a),
`endif
        .bist_busy(busy_a), .bistdone(done_a), .bistpass(pass_a));

    bist_ctrl_param #(.PI_W(4), .PO_W(4), .NUM_PATTERNS(40), .WARMUP(0),
        .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0000), .MISR_POLY(4'b1100), .GOLDEN_SIG(4'h0))
    u_b (.clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_po(zero4), .cut_pi(pi_b),
`ifdef BIST_SIG_DBG_EN
        .sig_out(sig_b), .pat_cnt(cnt_b),
`endif
        .bist_busy(busy_b), .bistdone(done_b), .bistpass(pass_b));

    bist_ctrl_param #(.PI_W(4), .PO_W(4), .NUM_PATTERNS(3), .WARMUP(0),
        .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b1100), .GOLDEN_SIG(4'b0111))
    u_c (.clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_po(one4), .cut_pi(pi_c),
`ifdef BIST_SIG_DBG_EN
        .sig_out(sig_c), .pat_cnt(cnt_c),
`endif
        .bist_busy(busy_c), .bistdone(done_c), .bistpass(pass_c));

    bist_ctrl_param #(.PI_W(4), .PO_W(4), .NUM_PATTERNS(3), .WARMUP(2),
        .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b1100), .GOLDEN_SIG(4'b0001))
    u_d (.clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_po(cut_po_d), .cut_pi(pi_d),
`ifdef BIST_SIG_DBG_EN
        .sig_out(sig_d), .pat_cnt(cnt_d),
`endif
        .bist_busy(busy_d), .bistdone(done_d), .bistpass(pass_d));

    bist_ctrl_param #(.PI_W(4), .PO_W(4), .NUM_PATTERNS(3), .WARMUP(0),
        .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b1100), .GOLDEN_SIG(4'b0110))
    u_e (.clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_po(one4), .cut_pi(pi_e),
`ifdef BIST_SIG_DBG_EN
        .sig_out(sig_e), .pat_cnt(cnt_e),
`endif
        .bist_busy(busy_e), .bistdone(done_e), .bistpass(pass_e));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; bistmode = 1'b0; pi = 4'hA; cut_po_d = 4'hF;
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_cutpi", 32'(pi_a), 32'hA);
        @(negedge clk);
        rst = 1'b1;
        bistmode = 1'b1;

        // Full runs of all configurations from a common start edge.
        for (int n = 1; n <= 44; n++) begin
            tick();
            if (n == 1) begin
                chk("init_busy", 32'(busy_a), 32'd1);
                chk("init_cutpi", 32'(pi_a), 32'h1);
            end
            if (n >= 2 && n <= 17)
                chk($sformatf("a_pat%0d", n - 2), 32'(pi_a), 32'(seq[(n - 2) % 15]));
            if (n >= 2 && n <= 41)
                chk($sformatf("b_pat%0d", n - 2), 32'(pi_b), 32'(seq[(n - 2) % 15]));
            if (n == 5) chk("c_done_early", 32'(done_c), 32'd0);
            if (n == 6) begin
                chk("c_done", 32'(done_c), 32'd1);
                chk("c_pass", 32'(pass_c), 32'd1);
                chk("e_done", 32'(done_e), 32'd1);
                chk("e_pass", 32'(pass_e), 32'd0);
                chk("d_warm_pass", 32'(pass_d), 32'd1);
            end
            if (n == 18) begin
                chk("a_done_early", 32'(done_a), 32'd0);
                chk("a_cmp_busy", 32'(busy_a), 32'd0);
            end
            if (n == 19) begin
                chk("a_done", 32'(done_a), 32'd1);
                chk("a_pass", 32'(pass_a), 32'd1);
                chk("a_hold_lfsr", 32'(pi_a), 32'h2);
            end
            if (n == 42) chk("b_done_early", 32'(done_b), 32'd0);
            if (n == 43) begin
                chk("b_done", 32'(done_b), 32'd1);
                chk("b_pass", 32'(pass_b), 32'd1);
            end
            cut_po_d = (n >= 4) ? 4'h1 : 4'hF;
        end

        // Leaving DONE clears the result.
        bistmode = 1'b0;
        tick();
        chk("exit_done", 32'(done_a), 32'd0);
        chk("exit_pass", 32'(pass_c), 32'd0);
        chk("exit_cutpi", 32'(pi_a), 32'hA);

        // Abort on RUN cycle 5.
        bistmode = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 3) chk("run1_pat1", 32'(pi_a), 32'h2);
            if (n == 6) chk("c_rerun_pass", 32'(pass_c), 32'd1);
        end
        bistmode = 1'b0;
        tick();
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_cutpi", 32'(pi_a), 32'hA);
        tick();
        tick();
        chk("abort_done", 32'(done_a), 32'd0);

        // Restart from seed, then async reset mid-RUN (A) and in DONE (C).
        bistmode = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 1) chk("restart_init", 32'(pi_a), 32'h1);
            if (n == 2) chk("restart_pat0", 32'(pi_a), 32'h1);
            if (n == 6) chk("restart_c_pass", 32'(pass_c), 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_cutpi", 32'(pi_a), 32'hA);
        chk("arst_done_c", 32'(done_c), 32'd0);
        chk("arst_pass_c", 32'(pass_c), 32'd0);
        @(negedge clk);
        bistmode = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_cutpi", 32'(pi_a), 32'hA);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
